// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: requester ids and sequencer states.
package mem_arbiter_pkg;

   typedef logic [1:0] req_id_t;

   localparam req_id_t R_FETCH = 2'd0;
   localparam req_id_t R_DATA  = 2'd1;
   localparam req_id_t R_LOAD  = 2'd2;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_BOOT  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, boot-handshake and memory-macro signals of the arbiter.
interface mem_arbiter_if #(
   parameter int AW = 9,
   parameter int DW = 16
);
   logic [2:0]    req;
   logic [2:0]    we;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [AW-1:0] addr2;
   logic [DW-1:0] wdata1;
   logic [DW-1:0] wdata2;
   logic [2:0]    gnt;
   logic [2:0]    rvalid;
   logic [DW-1:0] rdata;
   logic          boot_req;
   logic          boot_ack;
   logic          cpu_hold;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          mem_rden;
   logic [DW-1:0] mem_q;

   modport slave (
      input  req, we, addr0, addr1, addr2, wdata1, wdata2, boot_req, mem_q,
      output gnt, rvalid, rdata, boot_ack, cpu_hold, mem_addr, mem_wdata, mem_we, mem_rden
   );

   modport master (
      output req, we, addr0, addr1, addr2, wdata1, wdata2, boot_req, mem_q,
      input  gnt, rvalid, rdata, boot_ack, cpu_hold, mem_addr, mem_wdata, mem_we, mem_rden
   );
endinterface

// File: rtl/mem_arbiter_tag_pipe.sv
// Tracks outstanding reads: one valid+id stage per cycle of memory latency.
module arb_tag_pipe
   import mem_arbiter_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic    clk,
   input  logic    rstn,
   input  logic    push_i,
   input  req_id_t id_i,
   output logic    vld_o,
   output req_id_t id_o,
   output logic    empty_o
);

   logic    vld_q [RD_LAT];
   req_id_t id_q  [RD_LAT];

   // Shift the tags one stage per cycle; reset drops every in-flight tag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < RD_LAT; i++) begin
            vld_q[i] <= 1'b0;
            id_q[i]  <= R_FETCH;
         end
      end else begin
         vld_q[0] <= push_i;
         id_q[0]  <= id_i;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            id_q[i]  <= id_q[i-1];
         end
      end
   end

   // Empty means nothing remains once the entry (if any) at the output retires this cycle.
   always_comb begin
      empty_o = 1'b1;
      for (int i = 0; i < RD_LAT - 1; i++) begin
         if (vld_q[i]) empty_o = 1'b0;
      end
   end

   assign vld_o = vld_q[RD_LAT-1];
   assign id_o  = id_q[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch (r0), load/store (r1) and program loader (r2),
// with a boot sequencer that hands the memory to the loader.
//
// state    | meaning
// ST_RUN   | normal operation, r1 over r0 with starvation guard, r2 blocked
// ST_DRAIN | CPU held, no grants, waiting for in-flight reads to return
// ST_BOOT  | loader owns memory, only r2 granted, CPU held
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW     = 9,
   parameter int DW     = 16,
   parameter int RD_LAT = 1,
   parameter int STARVE = 4
) (
   input logic           clk,
   input logic           rstn,
   mem_arbiter_if.slave  bus
);

   localparam int CW = $clog2(STARVE + 1);

   arb_state_t    state_q;
   logic          boot_ack_q;
   logic          cpu_hold_q;
   // Remaining r1 grants allowed while r0 waits; r0 wins when this reaches zero.
   logic [CW-1:0] credit_q, credit_d;
   logic [2:0]    gnt;
   req_id_t       gnt_id;
   logic          any_gnt;
   logic          we_sel;
   logic [AW-1:0] addr_sel, addr_last_q;
   logic [DW-1:0] wdata_sel, wdata_last_q;
   logic          pipe_vld;
   req_id_t       pipe_id;
   logic          pipe_empty;

   // Grant selection and starvation credit update for the current cycle.
   always_comb begin
      gnt      = '0;
      gnt_id   = R_FETCH;
      credit_d = CW'(STARVE);
      case (state_q)
         ST_RUN: begin
            if (bus.req[R_DATA] && !(bus.req[R_FETCH] && credit_q == '0)) begin
               gnt[R_DATA] = 1'b1;
               gnt_id      = R_DATA;
               if (bus.req[R_FETCH]) credit_d = credit_q - CW'(1);
            end else if (bus.req[R_FETCH]) begin
               gnt[R_FETCH] = 1'b1;
               gnt_id       = R_FETCH;
            end
         end
         ST_BOOT: begin
            if (bus.req[R_LOAD] && bus.boot_req) begin
               gnt[R_LOAD] = 1'b1;
               gnt_id      = R_LOAD;
            end
         end
         default: ;
      endcase
   end

   // Address/data/direction mux from the granted requester; fetch is always a read.
   always_comb begin
      addr_sel  = addr_last_q;
      wdata_sel = wdata_last_q;
      we_sel    = 1'b0;
      case (gnt_id)
         R_DATA: begin
            addr_sel  = bus.addr1;
            wdata_sel = bus.wdata1;
            we_sel    = bus.we[R_DATA];
         end
         R_LOAD: begin
            addr_sel  = bus.addr2;
            wdata_sel = bus.wdata2;
            we_sel    = bus.we[R_LOAD];
         end
         default: addr_sel = bus.addr0;
      endcase
   end

   assign any_gnt = |gnt;

   // Boot sequencer with registered hold/ack outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_RUN;
         boot_ack_q <= 1'b0;
         cpu_hold_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (bus.boot_req) begin
                  state_q    <= ST_DRAIN;
                  cpu_hold_q <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (!bus.boot_req) begin
                  state_q    <= ST_RUN;
                  cpu_hold_q <= 1'b0;
               end else if (pipe_empty) begin
                  state_q    <= ST_BOOT;
                  boot_ack_q <= 1'b1;
               end
            end
            ST_BOOT: begin
               if (!bus.boot_req && pipe_empty) begin
                  state_q    <= ST_RUN;
                  boot_ack_q <= 1'b0;
                  cpu_hold_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_RUN;
               boot_ack_q <= 1'b0;
               cpu_hold_q <= 1'b0;
            end
         endcase
      end
   end

   // Starvation credit and the last driven address/data, held while idle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         credit_q     <= CW'(STARVE);
         addr_last_q  <= '0;
         wdata_last_q <= '0;
      end else begin
         credit_q <= credit_d;
         if (any_gnt) begin
            addr_last_q  <= addr_sel;
            wdata_last_q <= wdata_sel;
         end
      end
   end

   arb_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (bus.mem_rden),
      .id_i    (gnt_id),
      .vld_o   (pipe_vld),
      .id_o    (pipe_id),
      .empty_o (pipe_empty)
   );

   assign bus.gnt       = gnt;
   assign bus.mem_we    = any_gnt && we_sel;
   assign bus.mem_rden  = any_gnt && !we_sel;
   assign bus.mem_addr  = any_gnt ? addr_sel : addr_last_q;
   assign bus.mem_wdata = any_gnt ? wdata_sel : wdata_last_q;
   assign bus.rvalid    = pipe_vld ? (3'b001 << pipe_id) : 3'b000;
   assign bus.rdata     = pipe_vld ? bus.mem_q : '0;
   assign bus.boot_ack  = boot_ack_q;
   assign bus.cpu_hold  = cpu_hold_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural model on the RD_LAT=1 instance, literal checks on both.
module tb_mem_arbiter;

   localparam int STARVE = 4;
   localparam int M_RUN   = 0;
   localparam int M_DRAIN = 1;
   localparam int M_BOOT  = 2;

   logic clk;
   logic rstn;
   int   checks;
   int   errors;

   mem_arbiter_if #(.AW(9), .DW(16)) bus_a ();
   mem_arbiter_if #(.AW(9), .DW(16)) bus_b ();

   mem_arbiter #(.AW(9), .DW(16), .RD_LAT(1), .STARVE(STARVE)) dut_a (
      .clk (clk), .rstn (rstn), .bus (bus_a.slave)
   );
   mem_arbiter #(.AW(9), .DW(16), .RD_LAT(3), .STARVE(STARVE)) dut_b (
      .clk (clk), .rstn (rstn), .bus (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory macros: latency 1 for instance A, 3 for instance B.
   logic [15:0] mem_a [512];
   logic [15:0] mem_b [512];
   logic [15:0] q_a, q_b1, q_b2, q_b3;

   initial begin
      for (int i = 0; i < 512; i++) begin
         mem_a[i] = 16'hA000 ^ 16'(i);
         mem_b[i] = 16'hA000 ^ 16'(i);
      end
   end

   always @(posedge clk) begin
      if (bus_a.mem_we)   mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
      if (bus_a.mem_rden) q_a <= mem_a[bus_a.mem_addr];
      if (bus_b.mem_we)   mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
      if (bus_b.mem_rden) q_b1 <= mem_b[bus_b.mem_addr];
      q_b2 <= q_b1;
      q_b3 <= q_b2;
   end
   assign bus_a.mem_q = q_a;
   assign bus_b.mem_q = q_b3;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of instance A ----------------
   typedef struct {
      int          id;
      int          due;
      logic [15:0] data;
   } rd_t;

   rd_t         m_out[$];
   logic [15:0] shadow [512];
   int          m_mode;
   int          m_streak;
   int          cyc;
   logic [8:0]  m_last_addr;
   logic [15:0] m_last_wdata;

   initial begin
      for (int i = 0; i < 512; i++) shadow[i] = 16'hA000 ^ 16'(i);
      m_mode = M_RUN; m_streak = 0; cyc = 0;
      m_last_addr = '0; m_last_wdata = '0;
   end

   always @(negedge clk) begin : model
      int          gid;
      logic [2:0]  e_gnt;
      logic        e_we, e_rden, drained;
      logic [8:0]  e_addr, g_addr;
      logic [15:0] g_wdata;
      logic [2:0]  e_rv;
      logic [15:0] e_rdata;

      if (!rstn) begin
         m_mode = M_RUN; m_streak = 0; m_out.delete();
         m_last_addr = '0; m_last_wdata = '0;
      end

      gid = -1;
      if (m_mode == M_RUN) begin
         if (bus_a.req[1] && !(bus_a.req[0] && m_streak >= STARVE)) gid = 1;
         else if (bus_a.req[0]) gid = 0;
      end else if (m_mode == M_BOOT && bus_a.req[2] && bus_a.boot_req) begin
         gid = 2;
      end

      e_gnt   = (gid < 0) ? 3'b000 : 3'(1 << gid);
      g_addr  = (gid == 0) ? bus_a.addr0 : (gid == 1) ? bus_a.addr1 : bus_a.addr2;
      g_wdata = (gid == 1) ? bus_a.wdata1 : bus_a.wdata2;
      e_we    = (gid > 0) && bus_a.we[gid];
      e_rden  = (gid >= 0) && !e_we;
      e_addr  = (gid >= 0) ? g_addr : m_last_addr;
      e_rv    = 3'b000;
      e_rdata = 16'h0;
      if (m_out.size() > 0 && m_out[0].due == cyc) begin
         e_rv    = 3'(1 << m_out[0].id);
         e_rdata = m_out[0].data;
      end

      chk("gnt",      32'(bus_a.gnt),      32'(e_gnt));
      chk("mem_we",   32'(bus_a.mem_we),   32'(e_we));
      chk("mem_rden", 32'(bus_a.mem_rden), 32'(e_rden));
      chk("mem_addr", 32'(bus_a.mem_addr), 32'(e_addr));
      if (e_we) chk("mem_wdata", 32'(bus_a.mem_wdata), 32'(g_wdata));
      chk("rvalid",   32'(bus_a.rvalid),   32'(e_rv));
      chk("rdata",    32'(bus_a.rdata),    32'(e_rdata));
      chk("boot_ack", 32'(bus_a.boot_ack), 32'(m_mode == M_BOOT));
      chk("cpu_hold", 32'(bus_a.cpu_hold), 32'(m_mode != M_RUN));

      // Advance the model to the next cycle.
      while (m_out.size() > 0 && m_out[0].due <= cyc) void'(m_out.pop_front());
      drained = (m_out.size() == 0);
      if (rstn && gid >= 0) begin
         m_last_addr = g_addr;
         if (e_we) begin
            shadow[g_addr] = g_wdata;
            m_last_wdata   = g_wdata;
         end else begin
            m_out.push_back('{id: gid, due: cyc + 1, data: shadow[g_addr]});
         end
      end
      if (m_mode == M_RUN && gid == 1 && bus_a.req[0]) m_streak++;
      else m_streak = 0;
      if (rstn) begin
         case (m_mode)
            M_RUN:   if (bus_a.boot_req) m_mode = M_DRAIN;
            M_DRAIN: if (!bus_a.boot_req) m_mode = M_RUN;
                     else if (drained) m_mode = M_BOOT;
            default: if (!bus_a.boot_req && drained) m_mode = M_RUN;
         endcase
      end
      cyc++;
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      bus_a.req = 3'b000; bus_a.we = 3'b000;
   endtask

   initial begin : stim
      logic [9:0] seq;
      checks = 0; errors = 0;
      rstn = 1'b0;
      bus_a.req = '0; bus_a.we = '0; bus_a.addr0 = '0; bus_a.addr1 = '0; bus_a.addr2 = '0;
      bus_a.wdata1 = '0; bus_a.wdata2 = '0; bus_a.boot_req = 1'b0;
      bus_b.req = '0; bus_b.we = '0; bus_b.addr0 = '0; bus_b.addr1 = '0; bus_b.addr2 = '0;
      bus_b.wdata1 = '0; bus_b.wdata2 = '0; bus_b.boot_req = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_gnt",      32'(bus_a.gnt),      32'h0);
      chk("rst_rvalid",   32'(bus_a.rvalid),   32'h0);
      chk("rst_rdata",    32'(bus_a.rdata),    32'h0);
      chk("rst_boot_ack", 32'(bus_a.boot_ack), 32'h0);
      chk("rst_cpu_hold", 32'(bus_a.cpu_hold), 32'h0);
      chk("rst_mem_we",   32'(bus_a.mem_we),   32'h0);
      chk("rst_mem_rden", 32'(bus_a.mem_rden), 32'h0);
      step();
      rstn = 1'b1;

      // 1: single fetch read
      step();
      bus_a.req = 3'b001; bus_a.addr0 = 9'h005;
      @(negedge clk);
      chk("t1_gnt", 32'(bus_a.gnt), 32'h1);
      step();
      idle_a();
      @(negedge clk);
      chk("t1_rvalid", 32'(bus_a.rvalid), 32'h1);
      chk("t1_rdata",  32'(bus_a.rdata),  32'hA005);

      // 2: r0 and r1 both held, starvation guard lets r0 through every 5th cycle
      step();
      bus_a.req = 3'b011; bus_a.addr0 = 9'h020; bus_a.addr1 = 9'h030;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seq[i] = (bus_a.gnt == 3'b010);
         step();
      end
      idle_a();
      chk("t2_pattern", 32'(seq), 32'h1EF);

      // 3: r1 write then r0 read of the same word
      step();
      bus_a.req = 3'b010; bus_a.we = 3'b010; bus_a.addr1 = 9'h010; bus_a.wdata1 = 16'hBEEF;
      @(negedge clk);
      chk("t3_mem_we", 32'(bus_a.mem_we), 32'h1);
      step();
      bus_a.req = 3'b001; bus_a.we = 3'b000; bus_a.addr0 = 9'h010;
      step();
      idle_a();
      @(negedge clk);
      chk("t3_rdata", 32'(bus_a.rdata), 32'hBEEF);

      // 4: boot request with a read in flight
      step();
      bus_a.req = 3'b001; bus_a.addr0 = 9'h007; bus_a.boot_req = 1'b1;
      @(negedge clk);
      chk("t4_gnt", 32'(bus_a.gnt), 32'h1);
      step();
      bus_a.req = 3'b010; bus_a.addr1 = 9'h044;
      @(negedge clk);
      chk("t4_drain_hold",  32'(bus_a.cpu_hold), 32'h1);
      chk("t4_drain_ack",   32'(bus_a.boot_ack), 32'h0);
      chk("t4_drain_gnt",   32'(bus_a.gnt),      32'h0);
      chk("t4_drain_rdata", 32'(bus_a.rdata),    32'hA007);
      step();
      @(negedge clk);
      chk("t4_boot_ack", 32'(bus_a.boot_ack), 32'h1);
      chk("t4_boot_gnt", 32'(bus_a.gnt),      32'h0);

      // 5: loader writes four words, releases, fetch reads them back-to-back
      for (int k = 0; k < 4; k++) begin
         step();
         bus_a.req = 3'b100; bus_a.we = 3'b100;
         bus_a.addr2 = 9'(k); bus_a.wdata2 = 16'h1230 + 16'(k);
         @(negedge clk);
         chk("t5_load_gnt", 32'(bus_a.gnt), 32'h4);
      end
      step();
      idle_a();
      bus_a.boot_req = 1'b0;
      @(negedge clk);
      chk("t5_leave_ack", 32'(bus_a.boot_ack), 32'h1);
      step();
      @(negedge clk);
      chk("t5_run_ack",  32'(bus_a.boot_ack), 32'h0);
      chk("t5_run_hold", 32'(bus_a.cpu_hold), 32'h0);
      for (int k = 0; k < 5; k++) begin
         step();
         if (k < 4) begin
            bus_a.req = 3'b001; bus_a.addr0 = 9'(k);
         end else begin
            idle_a();
         end
         @(negedge clk);
         if (k > 0) begin
            chk("t5_rvalid", 32'(bus_a.rvalid), 32'h1);
            chk("t5_rdata",  32'(bus_a.rdata),  32'h1230 + 32'(k - 1));
         end
      end

      // 6: RD_LAT=3 latency, then reset with a read outstanding
      step();
      bus_b.req = 3'b001; bus_b.addr0 = 9'h009;
      @(negedge clk);
      chk("t6_gnt", 32'(bus_b.gnt), 32'h1);
      step();
      bus_b.req = 3'b000;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("t6_lat_rvalid", 32'(bus_b.rvalid), (k == 3) ? 32'h1 : 32'h0);
         if (k == 3) chk("t6_lat_rdata", 32'(bus_b.rdata), 32'hA009);
         step();
      end
      bus_b.req = 3'b001; bus_b.addr0 = 9'h00A;
      bus_a.req = 3'b001; bus_a.addr0 = 9'h00B;
      @(negedge clk);
      chk("t6_gnt2", 32'(bus_b.gnt), 32'h1);
      step();
      bus_b.req = 3'b000;
      idle_a();
      #2 rstn = 1'b0;
      @(negedge clk);
      chk("t6_rst_rvalid",   32'(bus_b.rvalid),   32'h0);
      chk("t6_rst_mem_addr", 32'(bus_b.mem_addr), 32'h0);
      step();
      rstn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t6_post_rvalid", 32'(bus_b.rvalid), 32'h0);
         chk("t6_post_rdata",  32'(bus_b.rdata),  32'h0);
         chk("t6_post_hold",   32'(bus_b.cpu_hold | bus_b.boot_ack | bus_b.mem_we | bus_b.mem_rden), 32'h0);
         step();
      end

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

endmodule
